// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags and flush.
// FWFT selects a combinational first-word-fall-through port or a registered one-cycle read port.
module fifo_sync_flags #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 8,
  parameter int ALMOST_FULL_TH  = 2**ADDR_WIDTH - 2,
  parameter int ALMOST_EMPTY_TH = 2,
  parameter int FWFT            = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  input  logic                  flush,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   w_ptr;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_set;
  logic                  udf_set;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Flush swallows both requests, so they neither move state nor raise errors.
  assign wr_acc  = write_en && !full  && !flush;
  assign rd_acc  = read_en  && !empty && !flush;
  assign ovf_set = write_en && full   && !flush;
  assign udf_set = read_en  && empty  && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !clear_err) || ovf_set;
      underflow <= (underflow && !clear_err) || udf_set;
      if (flush) begin
        w_ptr <= '0;
        r_ptr <= '0;
        count <= '0;
      end else begin
        if (wr_acc) w_ptr <= w_ptr + 1'b1;
        if (rd_acc) r_ptr <= r_ptr + 1'b1;
        case ({wr_acc, rd_acc})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr[ADDR_WIDTH-1:0]] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out   = mem[r_ptr[ADDR_WIDTH-1:0]];
      assign data_valid = !empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data;
      logic                  rd_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) rd_data <= mem[r_ptr[ADDR_WIDTH-1:0]];
        end
      end

      assign data_out   = rd_data;
      assign data_valid = rd_valid;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench: FWFT and registered-read instances driven by the same stimulus.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_en, read_en, flush, clear_err;
  logic [7:0] data_in;

  logic [7:0] f_data_out, r_data_out;
  logic       f_data_valid, r_data_valid;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic       r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic [4:0] f_count, r_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALMOST_FULL_TH(14),
                    .ALMOST_EMPTY_TH(2), .FWFT(1)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .flush(flush), .clear_err(clear_err),
    .data_out(f_data_out), .data_valid(f_data_valid), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf));

  fifo_sync_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALMOST_FULL_TH(14),
                    .ALMOST_EMPTY_TH(2), .FWFT(0)) dut_reg (
    .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .flush(flush), .clear_err(clear_err),
    .data_out(r_data_out), .data_valid(r_data_valid), .full(r_full),
    .empty(r_empty), .almost_full(r_af), .almost_empty(r_ae),
    .count(r_count), .overflow(r_ovf), .underflow(r_udf));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and sample 1 ns later, clear of the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 0; read_en = 0; flush = 0; clear_err = 0;
  endtask

  initial begin
    int exp_rd;
    int exp_wr;
    rst = 1; data_in = 8'h00;
    idle();
    #3;
    check("rst_count", f_count, 0);
    check("rst_empty", f_empty, 1);
    check("rst_full", f_full, 0);
    check("rst_ae", f_ae, 1);
    check("rst_af", f_af, 0);
    check("rst_ovf", f_ovf, 0);
    check("rst_udf", f_udf, 0);
    check("rst_fwft_valid", f_data_valid, 0);
    check("rst_reg_valid", r_data_valid, 0);
    check("rst_reg_dout", r_data_out, 0);
    #20 rst = 0;
    step();

    // Fill 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      write_en = 1; data_in = 8'(i);
      step();
      check($sformatf("fill_count%0d", i), f_count, i + 1);
      check($sformatf("fill_af%0d", i), f_af, (i + 1 >= 14) ? 1 : 0);
      check($sformatf("fill_ae%0d", i), f_ae, (i + 1 <= 2) ? 1 : 0);
      if (i == 0) begin
        check("fwft_first_dout", f_data_out, 8'h00);
        check("fwft_first_valid", f_data_valid, 1);
      end
    end
    check("full_flag", f_full, 1);
    data_in = 8'h10;
    step();
    check("ovf_set", f_ovf, 1);
    check("ovf_count", f_count, 16);
    write_en = 0;

    // Drain everything.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_fwft%0d", i), f_data_out, i);
      read_en = 1;
      step();
      check($sformatf("drain_reg%0d", i), r_data_out, i);
      check($sformatf("drain_regv%0d", i), r_data_valid, 1);
    end
    check("drain_empty", f_empty, 1);
    check("drain_count", f_count, 0);
    step();
    check("udf_set", f_udf, 1);
    check("udf_count", f_count, 0);
    check("udf_reg_valid", r_data_valid, 0);
    check("udf_reg_hold", r_data_out, 8'h0F);
    idle(); clear_err = 1;
    step();
    check("clr_ovf", f_ovf, 0);
    check("clr_udf", f_udf, 0);
    idle();

    // Empty with both requests: write wins, read is an underflow.
    write_en = 1; read_en = 1; data_in = 8'h55;
    step();
    check("eboth_count", f_count, 1);
    check("eboth_udf", f_udf, 1);
    check("eboth_dout", f_data_out, 8'h55);
    check("eboth_ovf", f_ovf, 0);
    read_en = 0;
    for (int i = 0; i < 15; i++) begin
      data_in = 8'(8'h56 + i);
      step();
    end
    check("refill_full", f_full, 1);
    // Full with both requests: read wins, write is an overflow.
    read_en = 1; data_in = 8'h77;
    step();
    check("fboth_count", f_count, 15);
    check("fboth_ovf", f_ovf, 1);
    check("fboth_dout", f_data_out, 8'h56);
    write_en = 0;
    for (int i = 0; i < 8; i++) step();
    check("pre_flush_count", f_count, 7);
    read_en = 0; write_en = 1; flush = 1; data_in = 8'hEE;
    step();
    check("flush_count", f_count, 0);
    check("flush_empty", f_empty, 1);
    check("flush_ovf", f_ovf, 1);
    check("flush_udf", f_udf, 1);
    check("flush_reg_valid", r_data_valid, 0);
    idle(); clear_err = 1;
    step();
    idle();

    // Wrap-around: prime 3 entries, stream 37 with read+write, then drain.
    exp_wr = 0; exp_rd = 0;
    for (int i = 0; i < 3; i++) begin
      write_en = 1; data_in = 8'(8'h80 + exp_wr); exp_wr++;
      step();
    end
    for (int i = 0; i < 40; i++) begin
      write_en = (exp_wr < 40); data_in = 8'(8'h80 + exp_wr);
      read_en = 1;
      if (f_data_out !== 8'(8'h80 + exp_rd) || i == 0 || i == 39)
        check($sformatf("wrap_fwft%0d", i), f_data_out, 8'h80 + exp_rd);
      if (write_en) exp_wr++;
      step();
      check($sformatf("wrap_reg%0d", i), r_data_out, 8'h80 + exp_rd);
      exp_rd++;
      if (f_count > 5 || (i < 37 && f_count != 3))
        check($sformatf("wrap_count%0d", i), f_count, (i < 37) ? 3 : 39 - i);
    end
    check("wrap_empty", f_empty, 1);
    check("wrap_udf", f_udf, 0);
    idle();

    // Registered read latency.
    write_en = 1; data_in = 8'hA5;
    step();
    write_en = 0; read_en = 1;
    step();
    check("reg_a5_dout", r_data_out, 8'hA5);
    check("reg_a5_valid", r_data_valid, 1);
    read_en = 0;
    step();
    check("reg_a5_valid_drop", r_data_valid, 0);
    check("reg_a5_hold", r_data_out, 8'hA5);

    // Asynchronous reset between edges.
    write_en = 1; data_in = 8'h3C;
    step(); step();
    write_en = 0;
    check("pre_arst_count", f_count, 2);
    #2 rst = 1;
    #1;
    check("arst_count", f_count, 0);
    check("arst_empty", f_empty, 1);
    check("arst_reg_dout", r_data_out, 0);
    check("arst_fwft_valid", f_data_valid, 0);
    #10 rst = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
